// File: rtl/freq_sweep_ctrl_pkg.sv
// Shared types and constants for the frequency sweep controller.
// Optional triangular sweep selected by defining SWEEP_BIDIR_EN.
package freq_sweep_ctrl_pkg;

  localparam int         FREQ_W_DEF  = 12;
  localparam int         DWELL_W_DEF = 16;
  localparam logic [2:0] AMP_MIN     = 3'd1;
  localparam logic [2:0] RST_AMP     = AMP_MIN;
  localparam logic [7:0] RST_PHASE   = 8'd0;
  localparam int         RST_DWELL   = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DWELL,
    S_STEP
`ifdef SWEEP_BIDIR_EN
    , S_DWELL_DN
    , S_STEP_DN
`endif
  } state_t;

endpackage

// File: rtl/freq_sweep_ctrl_dwell_timer.sv
// Dwell down-counter: load a hold length, count while enabled, flag the last cycle.
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_en,
  output logic               o_expire
);

  logic [DWELL_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DWELL_W'(1);
    end
  end

  // A load of N yields exactly N enabled cycles, the last one flagged.
  assign o_expire = i_en && (r_cnt == DWELL_W'(1));

endmodule

// File: rtl/freq_sweep_ctrl.sv
// Frequency sweep controller: sawtooth sweep by default, triangular
// up/down sweep when SWEEP_BIDIR_EN is defined. All outputs registered.
module freq_sweep_ctrl
  import freq_sweep_ctrl_pkg::*;
#(
  parameter int FREQ_W  = FREQ_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               cfg_load,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [2:0]         cfg_amp,
  input  logic [7:0]         cfg_phase,
  output logic [FREQ_W-1:0]  freq,
  output logic [2:0]         amp,
  output logic [7:0]         phase,
  output logic               en,
  output logic               busy,
  output logic               sweep_done
);

  state_t             r_state, w_state_nxt;
  logic [FREQ_W-1:0]  r_freq, w_freq_nxt;
  logic               r_en, w_en_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic [FREQ_W-1:0]  r_start_f, r_stop_f, r_step;
  logic [DWELL_W-1:0] r_dwell;
  logic [2:0]         r_amp;
  logic [7:0]         r_phase;
  logic               w_tmr_load, w_tmr_clr, w_tmr_en, w_expire;
  logic [FREQ_W:0]    w_up_sum;
  logic [FREQ_W-1:0]  w_up;

  // Extra bit keeps the sum from wrapping before the clamp to stop_freq.
  assign w_up_sum = {1'b0, r_freq} + {1'b0, r_step};
  assign w_up     = (w_up_sum > {1'b0, r_stop_f}) ? r_stop_f : w_up_sum[FREQ_W-1:0];

`ifdef SWEEP_BIDIR_EN
  logic [FREQ_W:0]   w_dn_diff;
  logic [FREQ_W-1:0] w_dn;
  assign w_dn_diff = {1'b0, r_freq} - {1'b0, r_step};
  assign w_dn      = (w_dn_diff[FREQ_W] || (w_dn_diff[FREQ_W-1:0] < r_start_f)) ?
                     r_start_f : w_dn_diff[FREQ_W-1:0];
  assign w_tmr_en  = (r_state == S_DWELL) || (r_state == S_DWELL_DN);
`else
  assign w_tmr_en  = (r_state == S_DWELL);
`endif

  dwell_timer #(.DWELL_W(DWELL_W)) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_tmr_clr),
    .i_load     (w_tmr_load),
    .i_load_val (r_dwell),
    .i_en       (w_tmr_en),
    .o_expire   (w_expire)
  );

  // Zero amp and zero dwell are promoted to 1 as they are latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_f <= '0;
      r_stop_f  <= '0;
      r_step    <= '0;
      r_dwell   <= DWELL_W'(RST_DWELL);
      r_amp     <= RST_AMP;
      r_phase   <= RST_PHASE;
    end else if (cfg_load && (r_state == S_IDLE)) begin
      r_start_f <= cfg_start_freq;
      r_stop_f  <= cfg_stop_freq;
      r_step    <= cfg_step;
      r_dwell   <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
      r_amp     <= (cfg_amp == 3'd0) ? AMP_MIN : cfg_amp;
      r_phase   <= cfg_phase;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_freq  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_freq  <= w_freq_nxt;
      r_en    <= w_en_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_freq_nxt  = r_freq;
    w_en_nxt    = r_en;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_clr   = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
      w_freq_nxt  = '0;
      w_en_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_tmr_clr   = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && (r_start_f <= r_stop_f)) begin
            w_state_nxt = S_DWELL;
            w_freq_nxt  = r_start_f;
            w_en_nxt    = 1'b1;
            w_busy_nxt  = 1'b1;
            w_tmr_load  = 1'b1;
          end
        end
        S_DWELL: begin
          if (w_expire) begin
            if (r_freq == r_stop_f) begin
`ifdef SWEEP_BIDIR_EN
              if (r_freq == r_start_f) begin
                w_done_nxt = 1'b1;
                w_tmr_load = 1'b1;
              end else begin
                w_state_nxt = S_STEP_DN;
              end
`else
              w_freq_nxt = r_start_f;
              w_done_nxt = 1'b1;
              w_tmr_load = 1'b1;
`endif
            end else begin
              w_state_nxt = S_STEP;
            end
          end
        end
        S_STEP: begin
          w_state_nxt = S_DWELL;
          w_freq_nxt  = w_up;
          w_tmr_load  = 1'b1;
        end
`ifdef SWEEP_BIDIR_EN
        S_DWELL_DN: begin
          if (w_expire) begin
            if (r_freq == r_start_f) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_STEP;
            end else begin
              w_state_nxt = S_STEP_DN;
            end
          end
        end
        S_STEP_DN: begin
          w_state_nxt = S_DWELL_DN;
          w_freq_nxt  = w_dn;
          w_tmr_load  = 1'b1;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign freq       = r_freq;
  assign amp        = r_amp;
  assign phase      = r_phase;
  assign en         = r_en;
  assign busy       = r_busy;
  assign sweep_done = r_done;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Directed self-checking bench for freq_sweep_ctrl (sawtooth build; the
// triangular sequence is exercised when SWEEP_BIDIR_EN is defined).
module tb_freq_sweep_ctrl;

  localparam int FW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0, stop = 1'b0, cfg_load = 1'b0;
  logic [FW-1:0] cfg_start_freq = '0, cfg_stop_freq = '0, cfg_step = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic [2:0]    cfg_amp = '0;
  logic [7:0]    cfg_phase = '0;
  logic [FW-1:0] freq;
  logic [2:0]    amp;
  logic [7:0]    phase;
  logic          en, busy, sweep_done;

  int n_asserts = 0;
  int n_fail    = 0;

  freq_sweep_ctrl #(.FREQ_W(FW), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .cfg_load(cfg_load),
    .cfg_start_freq(cfg_start_freq), .cfg_stop_freq(cfg_stop_freq),
    .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_amp(cfg_amp),
    .cfg_phase(cfg_phase), .freq(freq), .amp(amp), .phase(phase),
    .en(en), .busy(busy), .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int s, input int e, input int st, input int d,
                         input int a, input int p);
    cfg_start_freq = FW'(s);
    cfg_stop_freq  = FW'(e);
    cfg_step       = FW'(st);
    cfg_dwell      = DW'(d);
    cfg_amp        = 3'(a);
    cfg_phase      = 8'(p);
  endtask

  task automatic load_cfg();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_freq"}, 32'(freq), 0);
    chk({tag, "_amp"}, 32'(amp), 1);
    chk({tag, "_phase"}, 32'(phase), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(sweep_done), 0);
  endtask

  initial begin
    int exp_f;
    int clamp_f [6];
    clamp_f = '{0, 0, 4000, 4000, 4095, 0};

    #1 rst_n = 1'b0;
    #2 chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic sawtooth sweep
    set_cfg(100, 130, 10, 3, 3, 8'h20);
    load_cfg();
    chk("cfg_amp", 32'(amp), 3);
    chk("cfg_phase", 32'(phase), 32'h20);
    chk("cfg_idle_busy", 32'(busy), 0);
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      start = 1'b0;
      exp_f = (i < 4) ? 100 : (i < 8) ? 110 : (i < 12) ? 120 : (i < 15) ? 130 : 100;
      chk($sformatf("saw_freq%0d", i), 32'(freq), 32'(exp_f));
      chk($sformatf("saw_done%0d", i), 32'(sweep_done), (i == 15) ? 1 : 0);
      chk($sformatf("saw_en%0d", i), 32'(en), 1);
    end

    // Stop mid-DWELL
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_en", 32'(en), 0);
    chk("stop_freq", 32'(freq), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_amp_kept", 32'(amp), 3);
    chk("stop_phase_kept", 32'(phase), 32'h20);

    // Clamping at stop_freq, amp 0 promoted to 1
    set_cfg(0, 4095, 4000, 1, 0, 8'h5A);
    load_cfg();
    chk("amp0_to_1", 32'(amp), 1);
    start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      start = 1'b0;
      chk($sformatf("clamp_freq%0d", i), 32'(freq), 32'(clamp_f[i]));
    end
    chk("clamp_done", 32'(sweep_done), 1);

    // cfg_load while busy is ignored
    set_cfg(200, 100, 1, 1, 5, 8'h11);
    load_cfg();
    chk("busy_load_amp", 32'(amp), 1);
    chk("busy_load_phase", 32'(phase), 32'h5A);
    stop = 1'b1; tick(); stop = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("kept_bounds_start", 32'(freq), 0);
    chk("kept_bounds_busy", 32'(busy), 1);
    tick(); tick();
    chk("kept_step", 32'(freq), 4000);
    stop = 1'b1; tick(); stop = 1'b0;

    // start > stop bounds: start ignored
    load_cfg();
    chk("idle_load_amp", 32'(amp), 5);
    chk("idle_load_phase", 32'(phase), 32'h11);
    start = 1'b1; tick(); tick(); start = 1'b0;
    chk("badbounds_busy", 32'(busy), 0);
    chk("badbounds_en", 32'(en), 0);
    chk("badbounds_freq", 32'(freq), 0);

    // start and stop together in IDLE
    set_cfg(100, 130, 10, 3, 3, 8'h20);
    load_cfg();
    start = 1'b1; stop = 1'b1; tick();
    start = 1'b0; stop = 1'b0;
    chk("prio_busy", 32'(busy), 0);
    chk("prio_en", 32'(en), 0);

    // Zero dwell and zero step with start==stop
    set_cfg(50, 50, 0, 0, 2, 0);
    load_cfg();
    start = 1'b1; tick(); start = 1'b0;
    chk("flat_freq0", 32'(freq), 50);
    chk("flat_done0", 32'(sweep_done), 0);
    tick();
    chk("flat_done1", 32'(sweep_done), 1);
    chk("flat_freq1", 32'(freq), 50);
    tick();
    chk("flat_done2", 32'(sweep_done), 1);
    stop = 1'b1; tick(); stop = 1'b0;

    // Asynchronous reset mid-sweep
    set_cfg(100, 130, 10, 3, 3, 8'h20);
    load_cfg();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_async_freq", 32'(freq), 110);
    #3 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("post_rst_cfg_cleared", 32'(freq), 0);
    chk("post_rst_busy1", 32'(busy), 1);
    stop = 1'b1; tick(); stop = 1'b0;

`ifdef SWEEP_BIDIR_EN
    // Triangular sweep
    set_cfg(10, 30, 10, 1, 1, 0);
    load_cfg();
    start = 1'b1; tick(); start = 1'b0;
    chk("tri_e0", 32'(freq), 10);
    tick(); tick(); chk("tri_e2", 32'(freq), 20);
    tick(); tick(); chk("tri_e4", 32'(freq), 30);
    tick(); tick(); chk("tri_e6", 32'(freq), 20);
    tick(); tick(); chk("tri_e8", 32'(freq), 10);
    chk("tri_e8_done", 32'(sweep_done), 0);
    tick(); chk("tri_e9_done", 32'(sweep_done), 1);
    tick(); chk("tri_e10", 32'(freq), 20);
    stop = 1'b1; tick(); stop = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_sweep_ctrl.md
FREQ_SWEEP_CTRL -- requirements
Module: freq_sweep_ctrl

Interface
REQ-001 SHALL provide parameter FREQ_W, default 12, as the width of the frequency tuning word and step.
REQ-002 SHALL provide parameter DWELL_W, default 16, as the width of the dwell counter.
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a level sampled each edge that begins a sweep from IDLE.
REQ-006 SHALL have port stop, input, 1, a level sampled each edge that aborts the sweep.
REQ-007 SHALL have port cfg_load, input, 1, which latches the cfg_* inputs.
REQ-008 SHALL have ports cfg_start_freq, cfg_stop_freq and cfg_step, each input, FREQ_W wide, holding the sweep bounds and increment.
REQ-009 SHALL have ports cfg_dwell (input, DWELL_W, cycles per frequency), cfg_amp (input, 3, amplitude divisor) and cfg_phase (input, 8, channel-B phase offset).
REQ-010 SHALL have output freq, FREQ_W wide, the tuning word fed to the square generator.
REQ-011 SHALL have outputs amp (3 bits) and phase (8 bits), the latched configuration fed to the square generator.
REQ-012 SHALL have outputs en (generator enable), busy (state not IDLE) and sweep_done (1-cycle pulse), each 1 bit.

Function
REQ-013 SHALL implement states IDLE, DWELL and STEP; with SWEEP_BIDIR_EN defined, it SHALL also implement state DWELL_DN and state STEP_DN.
REQ-014 SHALL accept cfg_load only in IDLE and SHALL ignore cfg_load in every other state.
REQ-015 SHALL latch cfg_amp==0 as 1, because the downstream stage divides by amp.
REQ-016 SHALL treat cfg_dwell==0 as 1, so that each frequency is held for max(cfg_dwell,1) clk cycles.
REQ-017 On start in IDLE with latched start<=stop, the FSM SHALL set freq to start_freq, en to 1 and busy to 1 at the same edge, then enter DWELL with a full dwell count.
REQ-018 On start in IDLE with start_freq>stop_freq, the FSM SHALL ignore start and remain in IDLE.
REQ-019 When the dwell count expires, the FSM SHALL spend one cycle in STEP, which computes freq=min(freq+step, stop_freq) in FREQ_W+1 bits (no wrap on overflow), then re-enter DWELL.
REQ-020 Without SWEEP_BIDIR_EN, when the dwell expires while freq==stop_freq, the FSM SHALL load start_freq and pulse sweep_done for 1 cycle.
REQ-021 With cfg_step==0, freq SHALL stay constant and sweep_done SHALL never pulse, unless start_freq==stop_freq, in which case REQ-020 or REQ-022 SHALL apply.
REQ-022 With SWEEP_BIDIR_EN, reaching stop_freq SHALL reverse the sweep, the down path SHALL use freq=max(freq-step, start_freq), and the dwell expiring at start_freq SHALL pulse sweep_done and resume the up sweep.
REQ-023 stop SHALL return the FSM to IDLE at the next edge, with en=0, freq=0 and busy=0, while amp and phase are retained.
REQ-024 stop SHALL take priority when start and stop are asserted together.
REQ-025 start SHALL be ignored while busy.
REQ-026 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-027 rst_n low SHALL force IDLE, freq=0, amp=1, phase=0, en=0, busy=0, sweep_done=0, clear the dwell counter, and clear the latched configuration to start=stop=step=0, dwell=1.
REQ-028 Reset asserted mid-sweep SHALL take effect immediately and asynchronously, and a new sweep after release SHALL require cfg_load followed by start.

Configuration
REQ-029 Macro SWEEP_BIDIR_EN defined SHALL select the triangular up/down sweep of REQ-022.
REQ-030 Without SWEEP_BIDIR_EN, the block SHALL perform a sawtooth sweep per REQ-020, and the states DWELL_DN and STEP_DN SHALL not exist.

Structure
REQ-031 A shared package SHALL hold the state encoding typedef, FREQ_W/DWELL_W defaults, the amp minimum constant (1), and the reset values.
REQ-032 A single sub-module dwell_timer SHALL provide load, a down-counter and an expire pulse, and the FSM SHALL instantiate it once.

Verification
REQ-033 The bench SHALL check a basic sweep: load start=100, stop=130, step=10, dwell=3 and pulse start; freq SHALL be 100,110,120,130, each value held 3 cycles followed by a 1-cycle STEP, then 100 again with a sweep_done pulse (sawtooth).
REQ-034 The bench SHALL check clamping: start=0, stop=4095, step=4000; freq SHALL be 0, 4000, 4095 and never wrap below 4000.
REQ-035 The bench SHALL check abort priority: start and stop asserted together in IDLE SHALL leave busy=0; stop mid-DWELL SHALL give en=0 and freq=0 at the next edge.
REQ-036 The bench SHALL check config guarding: cfg_amp=0 SHALL give amp=1; cfg_load while busy SHALL leave amp, phase and bounds unchanged; start with start_freq=200, stop_freq=100 SHALL leave the FSM in IDLE.
REQ-037 The bench SHALL check async reset: rst_n low mid-sweep, between clock edges, SHALL drop all outputs to reset values before the next clk edge.
REQ-038 With SWEEP_BIDIR_EN and start=10, stop=30, step=10, dwell=1, the bench SHALL see freq 10,20,30,20,10 with sweep_done when the dwell at 10 expires, then 20 on the up sweep.
